// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory responder.
package mips_mem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Misaligned, or word index past the end of the RAM (full-width compare, no aliasing).
  function automatic logic addr_fault(input logic [ADDR_W-1:0]   addr,
                                      input logic [ADDR_W-3:0]   size_words);
    return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= size_words);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter for wait states; zero flag tells the FSM the wait is over.
module mem_wait_counter
  import mips_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec_en,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory req/ack interface with programmable wait states.
// Optional build macro DATA_MEM_BYTE_LANE_EN: stores honour per-byte enables;
// otherwise any store with a nonzero be writes the full word.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned SIZE = 128,
  parameter int unsigned WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IdxW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W-3:0] SizeWords = (ADDR_W-2)'(SIZE);
  localparam logic [WAIT_CNT_W-1:0] WaitLoad = (WAIT > 0) ? WAIT_CNT_W'(WAIT - 1) : '0;

  state_e            state_q, state_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [BE_W-1:0]   lat_be_q, lat_be_d;
  logic [DATA_W-1:0] mem_q [SIZE];

  logic              cnt_load, cnt_dec, cnt_zero;
  logic              wr_fire, mem_we;
  logic              src_we;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata, wr_word;
  logic [BE_W-1:0]   src_be;
  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic              resp, resp_fault;

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WaitLoad),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero)
  );

  // FSM next state, request latching and write-fire timing.
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    wr_fire     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          lat_we_d    = we;
          lat_addr_d  = addr;
          lat_wdata_d = wdata;
          lat_be_d    = be;
          if (WAIT == 0) begin
            state_d = StResp;
            wr_fire = 1'b1;
          end else begin
            state_d  = StWait;
            cnt_load = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = StResp;
          wr_fire = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write source: with zero wait states the store commits on the accepting edge,
  // so the live inputs are used; otherwise the latched copy.
  always_comb begin
    if (state_q == StIdle) begin
      src_we    = we;
      src_addr  = addr;
      src_wdata = wdata;
      src_be    = be;
    end else begin
      src_we    = lat_we_q;
      src_addr  = lat_addr_q;
      src_wdata = lat_wdata_q;
      src_be    = lat_be_q;
    end
  end

  assign wr_idx = src_addr[IdxW+1:2];
  assign rd_idx = lat_addr_q[IdxW+1:2];
  // be == 0 is a no-op store in both builds.
  assign mem_we = wr_fire && src_we && !addr_fault(src_addr, SizeWords) && (src_be != '0);

  // Merge new data with the old word per byte lane when enabled.
  always_comb begin
    wr_word = src_wdata;
`ifdef DATA_MEM_BYTE_LANE_EN
    for (int i = 0; i < BE_W; i++) begin
      if (!src_be[i]) begin
        wr_word[8*i +: 8] = mem_q[wr_idx][8*i +: 8];
      end
    end
`endif
  end

  // State and request-latch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
    end
  end

  // RAM array; reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  // Response outputs are decoded from state so they drop to zero with ack.
  always_comb begin
    resp       = (state_q == StResp);
    resp_fault = addr_fault(lat_addr_q, SizeWords);
    ack        = resp;
    err        = resp && resp_fault;
    rdata      = (resp && !lat_we_q && !resp_fault) ? mem_q[rd_idx] : '0;
    busy       = (state_q != StIdle);
  end

endmodule
